// File: rtl/ch_readout_seq.sv
// Serial readout sequencer: snapshots eight channel counts on a read request and
// walks the enabled channels in ascending order, shifting each one out MSB-first.
module ch_readout_seq #(
  parameter int unsigned DATA_W = 12
) (
  input  logic                     sclk,
  input  logic                     rstn,
  input  logic                     rd_start,
  input  logic [7:0]               ch_mask,
  input  logic [8*DATA_W-1:0]      ch_data,
  output logic [7:0]               load_cnt_ser,
  output logic [7:0]               raw_serial_out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [7:0]        mask_q, mask_d;
  logic [2:0]        cur_q, cur_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [7:0]        load_q, load_d;
  logic [7:0]        sel_dly_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] sreg_q [NUM_CH];

  logic              sreg_load_c;
  logic [2:0]        first_ch_c;
  logic [2:0]        next_ch_c;
  logic              higher_c;

  // Lowest enabled channel of the incoming request mask.
  always_comb begin
    first_ch_c = 3'd0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch_c = 3'(i);
    end
  end

  // Next enabled channel above the current one, if any.
  always_comb begin
    higher_c  = 1'b0;
    next_ch_c = cur_q;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_q))) begin
        higher_c  = 1'b1;
        next_ch_c = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cur_d       = cur_q;
    bitcnt_d    = bitcnt_q;
    sreg_load_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          if (ch_mask != 8'd0) begin
            sreg_load_c = 1'b1;
            mask_d      = ch_mask;
            cur_d       = first_ch_c;
            bitcnt_d    = '0;
            state_d     = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
          bitcnt_d = '0;
          if (higher_c) cur_d = next_ch_c;
          else          state_d = S_DONE;
        end else begin
          bitcnt_d = CNT_W'(bitcnt_q + 1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    load_d = (state_d == S_SHIFT) ? (8'd1 << cur_d) : 8'd0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      cur_q     <= '0;
      bitcnt_q  <= '0;
      load_q    <= '0;
      sel_dly_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cur_q     <= cur_d;
      bitcnt_q  <= bitcnt_d;
      load_q    <= load_d;
      sel_dly_q <= load_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Shift follows the select delayed by one cycle, in step with the mux.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NUM_CH); i++) sreg_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (sreg_load_c) sreg_q[i] <= ch_data[i*DATA_W +: DATA_W];
        else if (sel_dly_q[i]) sreg_q[i] <= {sreg_q[i][DATA_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    raw_serial_out = '0;
    for (int i = 0; i < int'(NUM_CH); i++) raw_serial_out[i] = sreg_q[i][DATA_W-1];
  end

  assign load_cnt_ser = load_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ch_readout_seq.sv
// Bench for ch_readout_seq: directed and random reads checked cycle by cycle
// against an expected trace built from the channel list and data words.
module tb_ch_readout_seq;

  localparam int DW  = 12;
  localparam int NCH = 8;

  logic              sclk = 1'b0;
  logic              rstn = 1'b1;
  logic              rd_start = 1'b0;
  logic [7:0]        ch_mask = 8'd0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [7:0]        load_cnt_ser;
  logic [7:0]        raw_serial_out;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  int exp_load[$];
  int exp_bch[$];
  int exp_bit[$];

  ch_readout_seq #(.DATA_W(DW)) dut (
    .sclk           (sclk),
    .rstn           (rstn),
    .rd_start       (rd_start),
    .ch_mask        (ch_mask),
    .ch_data        (ch_data),
    .load_cnt_ser   (load_cnt_ser),
    .raw_serial_out (raw_serial_out),
    .busy           (busy),
    .done           (done)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected trace, one entry per cycle from the accepting edge through DONE.
  task automatic build(input logic [7:0] m, input logic [NCH*DW-1:0] d);
    int chans[$];
    exp_load.delete(); exp_bch.delete(); exp_bit.delete();
    for (int c = 0; c < NCH; c++) if (m[c]) chans.push_back(c);
    foreach (chans[n]) for (int k = 0; k < DW; k++) exp_load.push_back(1 << chans[n]);
    exp_load.push_back(0);
    foreach (exp_load[j]) begin
      if (j == 0 || chans.size() == 0) begin
        exp_bch.push_back(-1);
        exp_bit.push_back(0);
      end else begin
        exp_bch.push_back(chans[(j-1)/DW]);
        exp_bit.push_back(int'(d[chans[(j-1)/DW]*DW + DW-1 - ((j-1)%DW)]));
      end
    end
  endtask

  task automatic rand_data(output logic [NCH*DW-1:0] d);
    for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'($urandom);
  endtask

  task automatic do_read(input string name, input logic [7:0] m, input logic [NCH*DW-1:0] d,
                         input int restart_at, input int change_at, input int abort_at);
    logic [NCH*DW-1:0] junk;
    int len;
    build(m, d);
    len = exp_load.size();
    @(negedge sclk);
    ch_mask = m; ch_data = d; rd_start = 1'b1;
    @(posedge sclk); #1;
    rd_start = 1'b0;
    for (int j = 0; j < len; j++) begin
      if (j == abort_at) begin
        rstn = 1'b0; #1;
        chk($sformatf("%s abort outputs", name), {load_cnt_ser, raw_serial_out, busy, done}, 32'd0);
        repeat (3) begin
          @(posedge sclk); #1;
          chk($sformatf("%s abort no done", name), {busy, done}, 32'd0);
        end
        @(negedge sclk); rstn = 1'b1;
        return;
      end
      chk($sformatf("%s load c%0d", name, j), load_cnt_ser, 32'(exp_load[j]));
      chk($sformatf("%s busy c%0d", name, j), busy, 32'd1);
      chk($sformatf("%s done c%0d", name, j), done, (j == len-1) ? 32'd1 : 32'd0);
      if (exp_bch[j] >= 0)
        chk($sformatf("%s bit c%0d", name, j), raw_serial_out[exp_bch[j]], 32'(exp_bit[j]));
      if (j == change_at) begin
        rand_data(junk);
        ch_data = junk; ch_mask = 8'($urandom);
      end
      rd_start = (j == restart_at);
      @(posedge sclk); #1;
    end
    rd_start = 1'b0;
    chk($sformatf("%s idle after", name), {load_cnt_ser, busy, done}, 32'd0);
  endtask

  initial begin
    logic [NCH*DW-1:0] d;
    logic [7:0] m;

    // Reset values, then a quiet stretch after release
    #2 rstn = 1'b0;
    #20;
    chk("reset outputs", {load_cnt_ser, raw_serial_out, busy, done}, 32'd0);
    @(negedge sclk); rstn = 1'b1;
    repeat (20) begin
      @(posedge sclk); #1;
      chk("quiet outputs", {load_cnt_ser, raw_serial_out, busy, done}, 32'd0);
    end

    rand_data(d); d[2*DW +: DW] = 12'hA5C;
    do_read("single", 8'h04, d, -1, -1, -1);

    rand_data(d); d[0 +: DW] = 12'hFFF; d[7*DW +: DW] = 12'h001;
    do_read("noncontig", 8'h81, d, -1, -1, -1);

    rand_data(d);
    do_read("empty", 8'h00, d, -1, -1, -1);

    rand_data(d);
    do_read("ignored start", 8'hFF, d, 40, -1, -1);

    rand_data(d); m = 8'($urandom) | 8'h01;
    do_read("snapshot", m, d, -1, 0, -1);

    rand_data(d);
    do_read("abort", 8'hFF, d, -1, -1, 3*DW + 5);
    chk("post abort raw", raw_serial_out, 32'd0);

    rand_data(d);
    do_read("after abort", 8'hFF, d, -1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      rand_data(d); m = 8'($urandom);
      do_read($sformatf("rand%0d", r), m, d, int'($urandom_range(0, 20)), int'($urandom_range(0, 5)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
